led_frame_scheduler: RTL and testbench
======================================

Name: led_frame_scheduler

Overview:
- Owns the 24x16 pixel frame buffer for the HT1632 LED matrix.
- Arbitrates pixel writes from two requesters, game logic (port A) and the text/scroll engine (port B).
- Sequences the panel bring-up commands, then on every frame tick assembles the 394-bit write sequence (3-bit ID, 7-bit address, 384 data bits).
- Hands each sequence to the bit-serial LED matrix driver through a valid/ready handshake.

Parameters:
- BRIGHTNESS, 4'd15, PWM duty field OR'd into the PWM_CONTROL command (0xA0 | BRIGHTNESS).
- NUM_COLS, 24, display columns; fixed by the 394-bit format and not to be overridden.
- NUM_ROWS, 16, rows per column (COMMON_16NMOS).

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per refresh period
- a_req  in  1  port A write request, held until a_ack
- a_col  in  5  port A column, 0..23
- a_row  in  4  port A row, 0..15
- a_val  in  1  port A pixel value
- a_ack  out  1  one-cycle grant for port A
- b_req, b_col, b_row, b_val, b_ack  same as port A, for port B
- seq  out  394  sequence to driver; MSB-justified within nbits
- nbits  out  32  number of bits to send (12 or 394)
- seq_valid  out  1  sequence offered
- seq_ready  in  1  driver idle and accepting
- init_done  out  1  high once all bring-up commands are accepted
- frame_drop  out  1  one-cycle pulse when a tick is lost

Behaviour:
- Reset values: seq=0, nbits=0, seq_valid=0, a_ack=b_ack=0, init_done=0, frame_drop=0. The frame buffer clears to 0, the round-robin pointer points to A, and the pending flag clears.
- Reset is honoured in any state. A seq_valid in flight drops on the next edge and bring-up restarts from command 0.
- Handshake: a transfer occurs on the edge where seq_valid&seq_ready=1. seq and nbits stay stable while valid is high. seq_valid falls the cycle after the transfer.
- Bring-up command encoding: ((4<<8)|cmd)<<1 in seq[11:0], with nbits=12.
- Bring-up order: 0x01, 0x03, 0x08, 0x14, 0x18, 0x24, 0xA0|BRIGHTNESS.
- States:
  - INIT_LOAD: load command idx; go to INIT_WAIT.
  - INIT_WAIT: on transfer, increment idx. If idx==6 go to IDLE and set init_done; otherwise go to INIT_LOAD.
  - IDLE: go to FRAME_LOAD if pending or frame_tick.
  - FRAME_LOAD: snapshot the buffer into seq, set nbits=394, clear pending; go to FRAME_WAIT.
  - FRAME_WAIT: on transfer, go to IDLE.
- Frame format:
  - seq[393:391]=3'b101, seq[390:384]=7'd0.
  - Pixel(col,row) maps to seq[383-(col*16+row)], so column 0, row 0 is sent first.
- Ticks:
  - Ticks before init_done are ignored, with no frame_drop.
  - A tick in FRAME_LOAD or FRAME_WAIT sets pending.
  - A tick while pending is already set pulses frame_drop and is otherwise discarded.
- Writes:
  - Writes are accepted in every state after reset, at most one per cycle.
  - Round-robin: when both ports request, grant the port not granted last. A lone requester is always granted.
  - The ack is asserted in the cycle the buffer bit is written.
  - A write with col>23 is acked and discarded.
- Simultaneous events:
  - A write in the FRAME_LOAD cycle is not in that snapshot; it appears in the next frame.
  - A tick in the same cycle as a FRAME_WAIT transfer sets pending.

Optional Feature:
- DOUBLE_BUFFER_EN
- Defined:
  - Writes go to a back buffer.
  - Adds input `swap_req` (1-bit pulse). It sets a swap flag.
  - In FRAME_LOAD with the swap flag set, the back buffer is copied to the front and then snapshotted, and the flag clears.
  - Without the swap flag, the front buffer is resent unchanged.
  - Reset clears both buffers and the flag.
- Undefined: there is a single live buffer, `swap_req` is absent, and the snapshot reads the live buffer.

Decomposition:
- Package led_matrix_pkg holds:
  - the HT1632 command constants;
  - SEQ_W=394, CMD_NBITS=12, FRAME_ID=3'b101;
  - the state enum;
  - a pixel-index function returning 383-(col*16+row).
- One sub-module: led_write_arbiter, the two-port round-robin arbiter producing grant, col, row and val.

Test Plan:
- Reset, then seq_ready=1 held → 7 transfers with nbits=12 and seq[11:0] = 0x802, 0x806, 0x810, 0x828, 0x830, 0x848, 0x95E (BRIGHTNESS=15); then init_done=1.
- Hold seq_ready=0 for 5 cycles during bring-up → seq and seq_valid stay stable; no command is skipped.
- Write A (0,0,1) and B (23,15,1) in the same cycle with the pointer at A → a_ack first, b_ack next cycle. The next frame has seq[383]=1, seq[0]=1 and seq[393:384]=10'b1010000000.
- Tick while in FRAME_WAIT, then a second tick → pending frame sent right after the first; frame_drop pulses once.
- Assert rst mid-frame with seq_valid=1 → seq_valid=0 and init_done=0 after the edge; bring-up restarts at command 0x802; the buffer reads all zero.
- With DOUBLE_BUFFER_EN: write (5,3,1), tick without swap → frame bit seq[383-83]=0; swap_req then tick → bit set.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - HT1632 command set, sequence geometry, scheduler states and pixel mapping.
package led_matrix_pkg;

  localparam int SEQ_W     = 394;
  localparam int CMD_NBITS = 12;
  localparam int NUM_PIX   = 384;

  localparam logic [2:0] FRAME_ID = 3'b101;
  localparam logic [2:0] CMD_ID   = 3'b100;

  localparam logic [7:0] CMD_SYS_EN      = 8'h01;
  localparam logic [7:0] CMD_LED_ON      = 8'h03;
  localparam logic [7:0] CMD_BLINK_OFF   = 8'h08;
  localparam logic [7:0] CMD_MASTER_MODE = 8'h14;
  localparam logic [7:0] CMD_INT_RC      = 8'h18;
  localparam logic [7:0] CMD_COM_16NMOS  = 8'h24;
  localparam logic [7:0] CMD_PWM_BASE    = 8'hA0;

  typedef enum logic [2:0] {
    INIT_LOAD,
    INIT_WAIT,
    IDLE,
    FRAME_LOAD,
    FRAME_WAIT
  } sched_state_t;

  // {col,row} equals col*16+row, so column 0 row 0 lands on the first bit sent.
  function automatic logic [8:0] pixel_index(input logic [4:0] col, input logic [3:0] row);
    return 9'd383 - {col, row};
  endfunction

endpackage

// File: rtl/led_write_arbiter.sv
// rtl/led_write_arbiter.sv - two-port round-robin pixel write arbiter, grant is combinational.
module led_write_arbiter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       a_req_i,
  input  logic [4:0] a_col_i,
  input  logic [3:0] a_row_i,
  input  logic       a_val_i,
  input  logic       b_req_i,
  input  logic [4:0] b_col_i,
  input  logic [3:0] b_row_i,
  input  logic       b_val_i,
  output logic       a_gnt_o,
  output logic       b_gnt_o,
  output logic       wr_en_o,
  output logic [4:0] wr_col_o,
  output logic [3:0] wr_row_o,
  output logic       wr_val_o
);

  logic prefer_b_q, prefer_b_d;

  always_comb begin
    a_gnt_o    = !rst_i && a_req_i && (!b_req_i || !prefer_b_q);
    b_gnt_o    = !rst_i && b_req_i && !a_gnt_o;
    wr_en_o    = a_gnt_o || b_gnt_o;
    wr_col_o   = b_gnt_o ? b_col_i : a_col_i;
    wr_row_o   = b_gnt_o ? b_row_i : a_row_i;
    wr_val_o   = b_gnt_o ? b_val_i : a_val_i;
    prefer_b_d = prefer_b_q;
    if (a_gnt_o) begin
      prefer_b_d = 1'b1;
    end else if (b_gnt_o) begin
      prefer_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prefer_b_q <= 1'b0;
    end else begin
      prefer_b_q <= prefer_b_d;
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// rtl/led_frame_scheduler.sv - HT1632 frame buffer, bring-up sequencer and frame launcher; DOUBLE_BUFFER_EN adds a swapped back buffer.
module led_frame_scheduler
  import led_matrix_pkg::*;
#(
  parameter logic [3:0] BRIGHTNESS = 4'd15,
  parameter int         NUM_COLS   = 24,
  parameter int         NUM_ROWS   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
`ifdef DOUBLE_BUFFER_EN
  input  logic             swap_req,
`endif
  input  logic             a_req,
  input  logic [4:0]       a_col,
  input  logic [3:0]       a_row,
  input  logic             a_val,
  output logic             a_ack,
  input  logic             b_req,
  input  logic [4:0]       b_col,
  input  logic [3:0]       b_row,
  input  logic             b_val,
  output logic             b_ack,
  output logic [SEQ_W-1:0] seq,
  output logic [31:0]      nbits,
  output logic             seq_valid,
  input  logic             seq_ready,
  output logic             init_done,
  output logic             frame_drop
);

  localparam logic [4:0] COL_LIMIT = 5'(NUM_COLS);
  localparam logic [4:0] ROW_LIMIT = 5'(NUM_ROWS);

  sched_state_t       state_q;
  logic [2:0]         cmd_idx_q;
  logic [SEQ_W-1:0]   seq_q;
  logic [31:0]        nbits_q;
  logic               seq_valid_q;
  logic               init_done_q;
  logic               frame_drop_q;
  logic               pending_q;
  logic [NUM_PIX-1:0] pix_q;
`ifdef DOUBLE_BUFFER_EN
  logic [NUM_PIX-1:0] front_q;
  logic               swap_q;
`endif

  logic       wr_en, wr_val, wr_hit, xfer, tick_live;
  logic [4:0] wr_col;
  logic [3:0] wr_row;
  logic [7:0] cmd_byte;

  led_write_arbiter u_arb (
    .clk_i    (clk),
    .rst_i    (rst),
    .a_req_i  (a_req),
    .a_col_i  (a_col),
    .a_row_i  (a_row),
    .a_val_i  (a_val),
    .b_req_i  (b_req),
    .b_col_i  (b_col),
    .b_row_i  (b_row),
    .b_val_i  (b_val),
    .a_gnt_o  (a_ack),
    .b_gnt_o  (b_ack),
    .wr_en_o  (wr_en),
    .wr_col_o (wr_col),
    .wr_row_o (wr_row),
    .wr_val_o (wr_val)
  );

  // Out-of-range columns are still acked by the arbiter but never reach the buffer.
  assign wr_hit    = wr_en && (wr_col < COL_LIMIT) && ({1'b0, wr_row} < ROW_LIMIT);
  assign xfer      = seq_valid_q && seq_ready;
  assign tick_live = frame_tick && init_done_q;

  always_comb begin
    cmd_byte = CMD_SYS_EN;
    case (cmd_idx_q)
      3'd0:    cmd_byte = CMD_SYS_EN;
      3'd1:    cmd_byte = CMD_LED_ON;
      3'd2:    cmd_byte = CMD_BLINK_OFF;
      3'd3:    cmd_byte = CMD_MASTER_MODE;
      3'd4:    cmd_byte = CMD_INT_RC;
      3'd5:    cmd_byte = CMD_COM_16NMOS;
      default: cmd_byte = CMD_PWM_BASE | {4'd0, BRIGHTNESS};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT_LOAD;
      cmd_idx_q    <= '0;
      seq_q        <= '0;
      nbits_q      <= '0;
      seq_valid_q  <= 1'b0;
      init_done_q  <= 1'b0;
      frame_drop_q <= 1'b0;
      pending_q    <= 1'b0;
      pix_q        <= '0;
`ifdef DOUBLE_BUFFER_EN
      front_q      <= '0;
      swap_q       <= 1'b0;
`endif
    end else begin
      frame_drop_q <= 1'b0;
      if (wr_hit) begin
        pix_q[pixel_index(wr_col, wr_row)] <= wr_val;
      end
      case (state_q)
        INIT_LOAD: begin
          seq_q       <= {{(SEQ_W-CMD_NBITS){1'b0}}, CMD_ID, cmd_byte, 1'b0};
          nbits_q     <= 32'(CMD_NBITS);
          seq_valid_q <= 1'b1;
          state_q     <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (xfer) begin
            seq_valid_q <= 1'b0;
            cmd_idx_q   <= cmd_idx_q + 3'd1;
            if (cmd_idx_q == 3'd6) begin
              init_done_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              state_q <= INIT_LOAD;
            end
          end
        end
        IDLE: begin
          if (pending_q || tick_live) begin
            state_q <= FRAME_LOAD;
          end
        end
        FRAME_LOAD: begin
`ifdef DOUBLE_BUFFER_EN
          if (swap_q) begin
            front_q <= pix_q;
            seq_q   <= {FRAME_ID, 7'd0, pix_q};
            swap_q  <= 1'b0;
          end else begin
            seq_q <= {FRAME_ID, 7'd0, front_q};
          end
`else
          seq_q       <= {FRAME_ID, 7'd0, pix_q};
`endif
          nbits_q     <= 32'(SEQ_W);
          seq_valid_q <= 1'b1;
          pending_q   <= 1'b0;
          state_q     <= FRAME_WAIT;
        end
        FRAME_WAIT: begin
          if (xfer) begin
            seq_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= INIT_LOAD;
      endcase
      // A busy-time tick queues one frame; any tick while one is queued is lost.
      if (tick_live) begin
        if (pending_q) begin
          frame_drop_q <= 1'b1;
        end else if (state_q == FRAME_LOAD || state_q == FRAME_WAIT) begin
          pending_q <= 1'b1;
        end
      end
`ifdef DOUBLE_BUFFER_EN
      if (swap_req) begin
        swap_q <= 1'b1;
      end
`endif
    end
  end

  assign seq        = seq_q;
  assign nbits      = nbits_q;
  assign seq_valid  = seq_valid_q;
  assign init_done  = init_done_q;
  assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb/tb_led_frame_scheduler.sv - randomized bench for led_frame_scheduler against a pixel-array reference model.
module tb_led_frame_scheduler;

  logic         clk = 1'b0;
  logic         rst, frame_tick, seq_ready;
  logic         a_req, a_val, b_req, b_val;
  logic [4:0]   a_col, b_col;
  logic [3:0]   a_row, b_row;
  logic         a_ack, b_ack, seq_valid, init_done, frame_drop;
  logic [393:0] seq;
  logic [31:0]  nbits;
`ifdef DOUBLE_BUFFER_EN
  logic         swap_req;
`endif

  led_frame_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
`ifdef DOUBLE_BUFFER_EN
    .swap_req   (swap_req),
`endif
    .a_req      (a_req),
    .a_col      (a_col),
    .a_row      (a_row),
    .a_val      (a_val),
    .a_ack      (a_ack),
    .b_req      (b_req),
    .b_col      (b_col),
    .b_row      (b_row),
    .b_val      (b_val),
    .b_ack      (b_ack),
    .seq        (seq),
    .nbits      (nbits),
    .seq_valid  (seq_valid),
    .seq_ready  (seq_ready),
    .init_done  (init_done),
    .frame_drop (frame_drop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [11:0] cmd_tab [7] = '{12'h802, 12'h806, 12'h810, 12'h828, 12'h830, 12'h848, 12'h95E};

  // reference model state
  logic [383:0] model_buf, snap_prev;
`ifdef DOUBLE_BUFFER_EN
  logic [383:0] model_front;
  bit           swap_pend;
`endif
  bit           pref_b, model_init, prev_valid, prev_xfer, mon_en;
  int           cmd_n, ticks_acc, frames_cnt, drops_cnt;
  logic [393:0] prev_seq, seen_seq;
  logic [31:0]  prev_nbits, seen_nbits;
  bit           lat_a, lat_b, new_offer, raw_prev_valid;

  task automatic check(input string tag, input logic [393:0] got, input logic [393:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $display("FAIL %s got=timeout exp=event", tag);
  endtask

  task automatic reset_model();
    model_buf  = '0;
    snap_prev  = '0;
`ifdef DOUBLE_BUFFER_EN
    model_front = '0;
    swap_pend   = 0;
`endif
    pref_b     = 0;
    model_init = 0;
    prev_valid = 0;
    prev_xfer  = 0;
    cmd_n      = 0;
    ticks_acc  = 0;
    frames_cnt = 0;
    drops_cnt  = 0;
  endtask

  task automatic observe();
    logic xfer, ea, eb;
    logic [393:0] exp_fr;
    int col, row;
    lat_a = a_ack;
    lat_b = b_ack;
    new_offer = seq_valid && !raw_prev_valid;
    raw_prev_valid = seq_valid;
    seen_seq = seq;
    seen_nbits = nbits;
    if (!mon_en) return;
    xfer = seq_valid && seq_ready;
    if (prev_valid && !prev_xfer) begin
      check("valid_hold", seq_valid, 1'b1);
      if (seq_valid) begin
        check("seq_hold", seq, prev_seq);
        check("nbits_hold", nbits, prev_nbits);
      end
    end
    if (prev_valid && prev_xfer) check("valid_fall", seq_valid, 1'b0);
    if (seq_valid && !prev_valid) begin
      if (cmd_n < 7) begin
        check("cmd_nbits", nbits, 394'd12);
        check("cmd_word", seq, {382'd0, cmd_tab[cmd_n]});
      end else begin
`ifdef DOUBLE_BUFFER_EN
        if (swap_pend) begin
          model_front = snap_prev;
          swap_pend = 0;
        end
        exp_fr = {10'b1010000000, model_front};
`else
        exp_fr = {10'b1010000000, snap_prev};
`endif
        check("frame_nbits", nbits, 394'd394);
        check("frame_data", seq, exp_fr);
      end
    end
    if (xfer) begin
      if (cmd_n < 7) cmd_n++;
      else frames_cnt++;
    end
    check("init_done", init_done, model_init);
    if (frame_tick && model_init) ticks_acc++;
    model_init = (cmd_n == 7);
    if (frame_drop) drops_cnt++;
    ea = a_req && (!b_req || !pref_b);
    eb = b_req && !ea;
    if (a_req || b_req) begin
      check("a_ack", a_ack, ea);
      check("b_ack", b_ack, eb);
    end
    snap_prev = model_buf;
    if (ea || eb) begin
      pref_b = ea;
      col = ea ? int'(a_col) : int'(b_col);
      row = ea ? int'(a_row) : int'(b_row);
      if (col < 24) model_buf[383 - (col * 16 + row)] = ea ? a_val : b_val;
    end
`ifdef DOUBLE_BUFFER_EN
    if (swap_req) swap_pend = 1;
`endif
    prev_valid = seq_valid;
    prev_xfer  = xfer;
    prev_seq   = seq;
    prev_nbits = nbits;
  endtask

  task automatic run_cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    if (lat_a) a_req = 1'b0;
    if (lat_b) b_req = 1'b0;
    frame_tick = 1'b0;
`ifdef DOUBLE_BUFFER_EN
    swap_req = 1'b0;
`endif
  endtask

  task automatic wait_frame(input string tag, output logic [393:0] fr);
    fr = '0;
    for (int i = 0; i < 300; i++) begin
      run_cycle();
      if (new_offer && seen_nbits == 32'd394) begin
        fr = seen_seq;
        return;
      end
    end
    timeout(tag);
  endtask

  task automatic wait_init(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (model_init) return;
      seq_ready  = ($urandom % 3) != 0;
      frame_tick = ($urandom % 5) == 0;
      run_cycle();
    end
    timeout(tag);
  endtask

  task automatic wait_offer(input string tag);
    for (int i = 0; i < 50; i++) begin
      run_cycle();
      if (new_offer) return;
    end
    timeout(tag);
  endtask

  logic [393:0] fr;
  int d0, f0;

  initial begin
    rst = 1'b1; frame_tick = 1'b0; seq_ready = 1'b0;
    a_req = 1'b0; a_col = '0; a_row = '0; a_val = 1'b0;
    b_req = 1'b0; b_col = '0; b_row = '0; b_val = 1'b0;
`ifdef DOUBLE_BUFFER_EN
    swap_req = 1'b0;
`endif
    mon_en = 0;
    reset_model();
    repeat (3) run_cycle();
    check("rst_seq", seq, 394'd0);
    check("rst_nbits", nbits, 394'd0);
    check("rst_valid", seq_valid, 1'b0);
    check("rst_acks", {a_ack, b_ack}, 2'b00);
    check("rst_init", init_done, 1'b0);
    check("rst_drop", frame_drop, 1'b0);

    // bring-up with an initial 5-cycle stall and early ticks that must be ignored
    rst = 1'b0;
    mon_en = 1;
    wait_offer("first_cmd");
    repeat (5) run_cycle();
    wait_init("bringup");
    seq_ready = 1'b1;
    run_cycle();
    check("init_up", init_done, 1'b1);

    // simultaneous writes, pointer at A
    a_req = 1'b1; a_col = 5'd0;  a_row = 4'd0;  a_val = 1'b1;
    b_req = 1'b1; b_col = 5'd23; b_row = 4'd15; b_val = 1'b1;
    run_cycle();
    check("ab_c1_a", lat_a, 1'b1);
    check("ab_c1_b", lat_b, 1'b0);
    run_cycle();
    check("ab_c2_a", lat_a, 1'b0);
    check("ab_c2_b", lat_b, 1'b1);
`ifdef DOUBLE_BUFFER_EN
    swap_req = 1'b1;
    run_cycle();
`endif
    frame_tick = 1'b1;
    wait_frame("ab_frame", fr);
    check("ab_first_px", fr[383], 1'b1);
    check("ab_last_px", fr[0], 1'b1);
    check("ab_header", fr[393:384], 10'b1010000000);
    repeat (3) run_cycle();

    // busy tick queues one frame, the next is dropped
    d0 = drops_cnt; f0 = frames_cnt;
    seq_ready = 1'b0;
    frame_tick = 1'b1;
    repeat (4) run_cycle();
    frame_tick = 1'b1;
    repeat (3) run_cycle();
    frame_tick = 1'b1;
    repeat (3) run_cycle();
    check("drop_once", drops_cnt - d0, 1);
    seq_ready = 1'b1;
    repeat (10) run_cycle();
    check("pending_frames", frames_cnt - f0, 2);
    check("drop_total", drops_cnt - d0, 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (!a_req && ($urandom % 3) == 0) begin
        a_req = 1'b1;
        a_col = (($urandom % 6) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
        a_row = 4'($urandom);
        a_val = 1'($urandom);
      end
      if (!b_req && ($urandom % 3) == 0) begin
        b_req = 1'b1;
        b_col = (($urandom % 6) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
        b_row = 4'($urandom);
        b_val = 1'($urandom);
      end
      frame_tick = ($urandom % 40) == 0;
      seq_ready  = ($urandom % 4) != 0;
      run_cycle();
    end
    seq_ready = 1'b1;
    repeat (40) run_cycle();
    check("tick_balance", frames_cnt + drops_cnt, ticks_acc);
    check("frames_seen", frames_cnt > 20, 1'b1);

    // reset while a frame is offered
    seq_ready = 1'b0;
    frame_tick = 1'b1;
    wait_frame("pre_rst_frame", fr);
    check("pre_rst_valid", seq_valid, 1'b1);
    mon_en = 0;
    rst = 1'b1;
    run_cycle();
    check("mid_rst_valid", seq_valid, 1'b0);
    check("mid_rst_init", init_done, 1'b0);
    rst = 1'b0;
    reset_model();
    mon_en = 1;
    seq_ready = 1'b1;
    wait_offer("restart");
    check("restart_cmd0", seen_seq[11:0], 12'h802);
    wait_init("rebringup");
    seq_ready = 1'b1;
    run_cycle();
    frame_tick = 1'b1;
    wait_frame("cleared_frame", fr);
    check("cleared_buf", fr[383:0], 384'd0);
    repeat (3) run_cycle();

`ifdef DOUBLE_BUFFER_EN
    a_req = 1'b1; a_col = 5'd5; a_row = 4'd3; a_val = 1'b1;
    repeat (2) run_cycle();
    frame_tick = 1'b1;
    wait_frame("db_noswap_frame", fr);
    check("db_noswap", fr[300], 1'b0);
    repeat (3) run_cycle();
    swap_req = 1'b1;
    run_cycle();
    frame_tick = 1'b1;
    wait_frame("db_swap_frame", fr);
    check("db_swap", fr[300], 1'b1);
    repeat (3) run_cycle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
